// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if
//   Bundles the upstream FIFO read port and the downstream valid/ready
//   stream used by fifo_rd_stream.
//   master modport (the adapter):
//     in : fifo_dout, fifo_empty, m_ready
//     out: fifo_rd_en, m_data, m_valid, level
//   slave modport (the environment): same signals, opposite directions.
interface fifo_rd_stream_if #(
   parameter int unsigned width = 9
);
   logic [width-1:0] fifo_dout;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [width-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic [1:0]       level;

   modport master (
      input  fifo_dout, fifo_empty, m_ready,
      output fifo_rd_en, m_data, m_valid, level
   );

   modport slave (
      output fifo_dout, fifo_empty, m_ready,
      input  fifo_rd_en, m_data, m_valid, level
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Converts a standard-mode (non-FWFT) FIFO read port with a fixed read
//   latency into a valid/ready stream. Reads are issued only when the
//   skid buffer is guaranteed to have room for the word when it arrives,
//   so the upstream FIFO never has to be stalled mid-read.
//   Ports:
//     clk           single clock, rising edge
//     rst           synchronous, active-high reset
//     bus (master)  fifo_dout/fifo_empty in, fifo_rd_en out,
//                   m_data/m_valid out, m_ready in, level out
//   Parameters:
//     width    data width (4..36)
//     latency  FIFO read latency in cycles (1 or 2)
module fifo_rd_stream #(
   parameter int unsigned width   = 9,
   parameter int unsigned latency = 1
) (
   input logic              clk,
   input logic              rst,
   fifo_rd_stream_if.master bus
);
   localparam int unsigned DEPTH   = latency + 1;
   localparam int unsigned PW      = (DEPTH > 2) ? 2 : 1;
   localparam logic [1:0]  DEPTH_L = 2'(DEPTH);
   localparam logic [PW-1:0] LAST_P = PW'(latency);

   if (latency < 1 || latency > 2) begin : g_bad_latency
      $error("fifo_rd_stream: latency must be 1 or 2");
   end
   if (width < 4 || width > 36) begin : g_bad_width
      $error("fifo_rd_stream: width must be in 4..36");
   end

   logic [width-1:0]   mem_q [DEPTH];
   logic [width-1:0]   mem_d [DEPTH];
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [1:0]         level_q, level_d;
   logic [latency-1:0] vld_q, vld_d;

   logic [1:0] inflight;
   logic [2:0] occ;
   logic       m_valid;
   logic       pop;
   logic       cap;
   logic       rd_en;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < latency; i++) begin
         inflight = inflight + {1'b0, vld_q[i]};
      end

      m_valid = (level_q != '0);
      pop     = m_valid & bus.m_ready;
      cap     = vld_q[latency-1];

      // Words already buffered plus words still in the FIFO pipeline, minus
      // the one leaving this cycle, must leave a free slot for a new read.
      occ   = {1'b0, level_q} + {1'b0, inflight} - {2'b00, pop};
      rd_en = !rst && !bus.fifo_empty && (occ < {1'b0, DEPTH_L});

      // Oldest stage drops off; newest stage is this cycle's strobe.
      vld_d = latency'({vld_q, rd_en});

      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q + {1'b0, cap} - {1'b0, pop};

      if (cap) begin
         mem_d[tail_q] = bus.fifo_dout;
         tail_d        = (tail_q == LAST_P) ? '0 : tail_q + PW'(1);
      end
      if (pop) begin
         head_d = (head_q == LAST_P) ? '0 : head_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
         vld_q   <= vld_d;
      end
      mem_q <= mem_d;
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = m_valid;
   assign bus.m_data     = mem_q[head_q];
   assign bus.level      = level_q;

   // A capture into a full buffer would mean the read throttle is broken.
   ovf_chk: assert property (@(posedge clk) disable iff (rst)
      !(cap && !pop && (level_q == DEPTH_L)));
endmodule
